// File: rtl/trdb_branch_map.sv
// Branch map for trace packets: accumulates branch outcomes (1 = not taken)
// until the packet emitter flushes them, flagging outcomes dropped while full.
module trdb_branch_map #(
  parameter int MAP_LEN = 31
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic                           valid_i,
  input  logic                           branch_taken_i,
  input  logic                           flush_i,
  output logic [MAP_LEN-1:0]             map_o,
  output logic [$clog2(MAP_LEN+1)-1:0]   branches_o,
  output logic                           is_full_o,
  output logic                           is_empty_o,
  output logic                           overflow_o
);

  localparam int CW = $clog2(MAP_LEN+1);

  logic [MAP_LEN-1:0] map_reg, map_next;
  logic [CW-1:0]      count_reg, count_next;
  logic               overflow_reg, overflow_next;
  logic               full;

  assign full = (count_reg == CW'(MAP_LEN));

  // A flush restarts the map; a branch in the same cycle lands in bit 0.
  // When full, count_reg matches no bit index, so the outcome is dropped.
  generate
    for (genvar gi = 0; gi < MAP_LEN; gi++) begin : g_bit
      assign map_next[gi] = flush_i
          ? ((gi == 0) && valid_i && !branch_taken_i)
          : ((valid_i && (count_reg == CW'(gi))) ? !branch_taken_i : map_reg[gi]);
    end
  endgenerate

  always_comb begin
    count_next = count_reg;
    if (flush_i) begin
      count_next = valid_i ? CW'(1) : '0;
    end else if (valid_i && !full) begin
      count_next = count_reg + CW'(1);
    end
  end

  assign overflow_next = valid_i && !flush_i && full;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      map_reg      <= '0;
      count_reg    <= '0;
      overflow_reg <= 1'b0;
    end else begin
      map_reg      <= map_next;
      count_reg    <= count_next;
      overflow_reg <= overflow_next;
    end
  end

  assign map_o      = map_reg;
  assign branches_o = count_reg;
  assign overflow_o = overflow_reg;
  assign is_full_o  = (count_reg == CW'(MAP_LEN));
  assign is_empty_o = (count_reg == '0);

endmodule
